// File: rtl/ps2_rx_fifo_ctrl_if.sv
// Bundle between the PS/2 receive controller, its scan-code decoder and the 68k bus interface.
// The master side is the decoder/CPU pair; the slave side is ps2_rx_fifo_ctrl.
interface ps2_rx_fifo_ctrl_if;
  logic       dec_valid;
  logic [7:0] dec_data;
  logic       dec_clr;
  logic       rd_req;
  logic       rd_sel;
  logic       wr_req;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_ack;
  logic       irq_n;
  logic [3:0] count;

  modport master (
    output dec_valid, dec_data, rd_req, rd_sel, wr_req, wr_data,
    input  dec_clr, rd_data, rd_ack, irq_n, count
  );

  modport slave (
    input  dec_valid, dec_data, rd_req, rd_sel, wr_req, wr_data,
    output dec_clr, rd_data, rd_ack, irq_n, count
  );
endinterface

// File: rtl/ps2_rx_fifo_ctrl.sv
// PS/2 receive sequencer: captures decoder bytes once each, buffers them in a FIFO for the 68k,
// and exposes DATA/STATUS reads, a CTRL write and an active-low interrupt.
module ps2_rx_fifo_ctrl #(
  parameter int DEPTH_LOG2 = 3
) (
  input logic             clk,
  input logic             rst_n,
  ps2_rx_fifo_ctrl_if.slave bus
);

  localparam int         DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [3:0] FULL_COUNT = 4'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_WAIT} state_t;

  state_t                 state_reg, state_next;
  logic [7:0]             mem [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [3:0]             count_reg;
  logic                   ovf_reg, irq_en_reg, dec_clr_reg, rd_ack_reg, irq_n_reg;
  logic [7:0]             rd_data_reg;

  logic       capture, full, empty, push, pop, ovf_set, ovf_clr, flush;
  logic [7:0] status;

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.dec_valid) begin
          capture    = 1'b1;
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: state_next = ST_WAIT;
      // Hold here while the decoder keeps valid up so a byte is never taken twice.
      ST_WAIT:  if (!bus.dec_valid) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign full    = (count_reg == FULL_COUNT);
  assign empty   = (count_reg == 4'd0);
  assign push    = capture & ~full;
  assign ovf_set = capture & full;
  assign pop     = bus.rd_req & ~bus.rd_sel & ~empty;
  assign flush   = bus.wr_req & bus.wr_data[1];
  assign ovf_clr = bus.wr_req & bus.wr_data[2];
  assign status  = {ovf_reg, irq_en_reg, full, empty, count_reg};

  // Storage carries no reset so it can map onto block RAM; a pushed byte under flush is harmless.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= bus.dec_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= 4'd0;
      ovf_reg     <= 1'b0;
      irq_en_reg  <= 1'b0;
      dec_clr_reg <= 1'b0;
      rd_ack_reg  <= 1'b0;
      rd_data_reg <= 8'h00;
      irq_n_reg   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      // Clear pulse trails the CLEAR state by one edge so the byte is already safely stored.
      dec_clr_reg <= (state_reg == ST_CLEAR);
      rd_ack_reg  <= bus.rd_req;
      irq_n_reg   <= ~(irq_en_reg & (~empty | ovf_reg));

      if (bus.rd_req) begin
        if (bus.rd_sel)  rd_data_reg <= status;
        else if (empty)  rd_data_reg <= 8'h00;
        else             rd_data_reg <= mem[rd_ptr_reg];
      end

      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= 4'd0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
        count_reg <= count_reg + {3'b000, push} - {3'b000, pop};
      end

      if (bus.wr_req) irq_en_reg <= bus.wr_data[0];

      if (ovf_set)      ovf_reg <= 1'b1;
      else if (ovf_clr) ovf_reg <= 1'b0;
    end
  end

  assign bus.dec_clr = dec_clr_reg;
  assign bus.rd_data = rd_data_reg;
  assign bus.rd_ack  = rd_ack_reg;
  assign bus.irq_n   = irq_n_reg;
  assign bus.count   = count_reg;

endmodule

// File: tb/tb_ps2_rx_fifo_ctrl.sv
// Directed bench for ps2_rx_fifo_ctrl: capture sequencing, FIFO order/wrap, overflow,
// flush, empty reads and asynchronous reset, with hand-computed expectations.
module tb_ps2_rx_fifo_ctrl;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  ps2_rx_fifo_ctrl_if bus ();

  ps2_rx_fifo_ctrl #(.DEPTH_LOG2(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic do_read(input logic sel, output logic [7:0] data, output logic ack);
    @(negedge clk);
    bus.rd_req = 1'b1;
    bus.rd_sel = sel;
    @(posedge clk);
    #1;
    data = bus.rd_data;
    ack  = bus.rd_ack;
    $display("read  sel=%0d data=%h ack=%0d count=%0d", sel, data, ack, bus.count);
    @(negedge clk);
    bus.rd_req = 1'b0;
    bus.rd_sel = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] value);
    @(negedge clk);
    bus.wr_req  = 1'b1;
    bus.wr_data = value;
    $display("write ctrl=%h", value);
    @(negedge clk);
    bus.wr_req  = 1'b0;
    bus.wr_data = 8'h00;
  endtask

  // One full capture: valid for one edge, then enough idle edges for the FSM to get back to IDLE.
  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    bus.dec_valid = 1'b1;
    bus.dec_data  = b;
    @(negedge clk);
    bus.dec_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("push  byte=%h count=%0d", b, bus.count);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic       a;
    do_write(8'h01);
    push_byte(8'h77);
    do_read(1'b1, d, a);
    @(posedge clk);
    #1;
    checks++;
    if (bus.irq_n !== 1'b0) begin
      errors++; $display("FAIL reset_pre_irq: got %b expected 0", bus.irq_n);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.count !== 4'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", bus.count);
    end
    checks++;
    if (bus.irq_n !== 1'b1) begin
      errors++; $display("FAIL reset_irq_n: got %b expected 1", bus.irq_n);
    end
    checks++;
    if (bus.rd_data !== 8'h00) begin
      errors++; $display("FAIL reset_rd_data: got %h expected 00", bus.rd_data);
    end
    checks++;
    if (bus.rd_ack !== 1'b0 || bus.dec_clr !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got ack=%b clr=%b expected 0 0", bus.rd_ack, bus.dec_clr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_byte();
    logic [7:0] d;
    logic       a;
    int         extra_clr;
    do_write(8'h01);
    @(negedge clk);
    bus.dec_valid = 1'b1;
    bus.dec_data  = 8'h1C;
    @(posedge clk); #1;
    checks++;
    if (bus.count !== 4'd1 || bus.dec_clr !== 1'b0) begin
      errors++; $display("FAIL single_e0: got count=%0d clr=%b expected 1 0", bus.count, bus.dec_clr);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.dec_clr !== 1'b1 || bus.irq_n !== 1'b0) begin
      errors++; $display("FAIL single_e1: got clr=%b irq_n=%b expected 1 0", bus.dec_clr, bus.irq_n);
    end
    extra_clr = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.dec_clr === 1'b1) extra_clr++;
    end
    checks++;
    if (extra_clr !== 0 || bus.count !== 4'd1) begin
      errors++; $display("FAIL single_hold: got extra_clr=%0d count=%0d expected 0 1", extra_clr, bus.count);
    end
    @(negedge clk);
    bus.dec_valid = 1'b0;
    repeat (2) @(negedge clk);
    do_read(1'b0, d, a);
    checks++;
    if (d !== 8'h1C || a !== 1'b1) begin
      errors++; $display("FAIL single_read: got data=%h ack=%b expected 1c 1", d, a);
    end
    checks++;
    if (bus.count !== 4'd0) begin
      errors++; $display("FAIL single_count_after: got %0d expected 0", bus.count);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.irq_n !== 1'b1) begin
      errors++; $display("FAIL single_irq_release: got %b expected 1", bus.irq_n);
    end
  endtask

  task automatic test_order_wrap();
    logic [7:0] d;
    logic       a;
    logic [7:0] exp_q [8];
    exp_q = '{8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hA0, 8'hA1, 8'hA2};
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    // ovf=0 irq_en=1 full=1 empty=0 count=8
    do_read(1'b1, d, a);
    checks++;
    if (d !== 8'h68) begin
      errors++; $display("FAIL wrap_status_full: got %h expected 68", d);
    end
    for (int i = 0; i < 3; i++) begin
      do_read(1'b0, d, a);
      checks++;
      if (d !== 8'h10 + 8'(i)) begin
        errors++; $display("FAIL wrap_pop%0d: got %h expected %h", i, d, 8'h10 + 8'(i));
      end
    end
    for (int i = 0; i < 3; i++) push_byte(8'hA0 + 8'(i));
    for (int i = 0; i < 8; i++) begin
      do_read(1'b0, d, a);
      checks++;
      if (d !== exp_q[i]) begin
        errors++; $display("FAIL wrap_drain%0d: got %h expected %h", i, d, exp_q[i]);
      end
    end
    checks++;
    if (bus.count !== 4'd0) begin
      errors++; $display("FAIL wrap_count_end: got %0d expected 0", bus.count);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] d;
    logic       a;
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i));
    @(negedge clk);
    bus.dec_valid = 1'b1;
    bus.dec_data  = 8'h55;
    bus.rd_req    = 1'b1;
    bus.rd_sel    = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.rd_data !== 8'h20 || bus.count !== 4'd7) begin
      errors++; $display("FAIL ovf_push_pop: got data=%h count=%0d expected 20 7", bus.rd_data, bus.count);
    end
    @(negedge clk);
    bus.rd_req    = 1'b0;
    bus.dec_valid = 1'b0;
    repeat (2) @(negedge clk);
    // ovf=1 irq_en=1 full=0 empty=0 count=7
    do_read(1'b1, d, a);
    checks++;
    if (d !== 8'hC7) begin
      errors++; $display("FAIL ovf_status_set: got %h expected c7", d);
    end
    do_write(8'h05);
    do_read(1'b1, d, a);
    checks++;
    if (d !== 8'h47) begin
      errors++; $display("FAIL ovf_status_clear: got %h expected 47", d);
    end
    for (int i = 1; i < 8; i++) begin
      do_read(1'b0, d, a);
      checks++;
      if (d !== 8'h20 + 8'(i)) begin
        errors++; $display("FAIL ovf_drain%0d: got %h expected %h", i, d, 8'h20 + 8'(i));
      end
    end
  endtask

  task automatic test_empty_flush();
    logic [7:0] d;
    logic       a;
    do_read(1'b0, d, a);
    checks++;
    if (d !== 8'h00 || a !== 1'b1 || bus.count !== 4'd0) begin
      errors++; $display("FAIL empty_read: got data=%h ack=%b count=%0d expected 00 1 0", d, a, bus.count);
    end
    for (int i = 0; i < 4; i++) push_byte(8'h30 + 8'(i));
    @(negedge clk);
    bus.wr_req    = 1'b1;
    bus.wr_data   = 8'h02;
    bus.dec_valid = 1'b1;
    bus.dec_data  = 8'h99;
    @(posedge clk); #1;
    checks++;
    if (bus.count !== 4'd0) begin
      errors++; $display("FAIL flush_count: got %0d expected 0", bus.count);
    end
    @(negedge clk);
    bus.wr_req    = 1'b0;
    bus.dec_valid = 1'b0;
    repeat (2) @(negedge clk);
    do_read(1'b1, d, a);
    checks++;
    if (d !== 8'h10) begin
      errors++; $display("FAIL flush_status: got %h expected 10", d);
    end
    checks++;
    if (bus.irq_n !== 1'b1) begin
      errors++; $display("FAIL flush_irq_n: got %b expected 1", bus.irq_n);
    end
  endtask

  task automatic test_reset_mid_capture();
    logic [7:0] d;
    logic       a;
    for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(i));
    @(negedge clk);
    bus.dec_valid = 1'b1;
    bus.dec_data  = 8'h45;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.count !== 4'd0 || bus.dec_clr !== 1'b0) begin
      errors++; $display("FAIL midrst_async: got count=%0d clr=%b expected 0 0", bus.count, bus.dec_clr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.count !== 4'd1 || bus.dec_clr !== 1'b0) begin
      errors++; $display("FAIL midrst_recapture: got count=%0d clr=%b expected 1 0", bus.count, bus.dec_clr);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.dec_clr !== 1'b1) begin
      errors++; $display("FAIL midrst_clr: got %b expected 1", bus.dec_clr);
    end
    @(negedge clk);
    bus.dec_valid = 1'b0;
    repeat (2) @(negedge clk);
    do_read(1'b0, d, a);
    checks++;
    if (d !== 8'h45 || bus.count !== 4'd0) begin
      errors++; $display("FAIL midrst_read: got data=%h count=%0d expected 45 0", d, bus.count);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.dec_valid = 1'b0;
    bus.dec_data  = 8'h00;
    bus.rd_req    = 1'b0;
    bus.rd_sel    = 1'b0;
    bus.wr_req    = 1'b0;
    bus.wr_data   = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    test_reset();
    test_single_byte();
    test_order_wrap();
    test_overflow();
    test_empty_flush();
    test_reset_mid_capture();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
